ape_tcdm_crypt_bridge: RTL and testbench

- Parametrised TCDM interposer between a core-side TCDM port (slave side) and the memory-side TCDM port (master side).
- Forwards requests and tracks up to OUTSTANDING in-flight transactions in a FIFO.
- XOR-decrypts read data whose address hits a configurable window.
- Registers the last decrypted value as ape Vc state.

---
 rtl/ape_tcdm_crypt_bridge.sv | 157 +++++++++++++++
 tb/tb_ape_tcdm_crypt_bridge.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ape_tcdm_crypt_bridge.sv
// TCDM interposer: forwards requests, tracks in-flight transactions and XOR-decrypts windowed reads.
// Optional performance counters are enabled by defining APE_CORE_PERF_EN.
module ape_tcdm_crypt_bridge #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned OUTSTANDING = 4,
    parameter int unsigned VC_WIDTH    = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           s_req_i,
    input  logic [ADDR_WIDTH-1:0]          s_add_i,
    input  logic                           s_wen_i,
    input  logic [DATA_WIDTH-1:0]          s_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]        s_be_i,
    output logic                           s_gnt_o,
    output logic [DATA_WIDTH-1:0]          s_r_rdata_o,
    output logic                           s_r_valid_o,
    output logic                           m_req_o,
    output logic [ADDR_WIDTH-1:0]          m_add_o,
    output logic                           m_wen_o,
    output logic [DATA_WIDTH-1:0]          m_wdata_o,
    output logic [DATA_WIDTH/8-1:0]        m_be_o,
    input  logic                           m_gnt_i,
    input  logic [DATA_WIDTH-1:0]          m_r_rdata_i,
    input  logic                           m_r_valid_i,
    input  logic                           cfg_en_i,
    input  logic [DATA_WIDTH-1:0]          cfg_key_i,
    input  logic [ADDR_WIDTH-1:0]          cfg_base_i,
    input  logic [ADDR_WIDTH-1:0]          cfg_mask_i,
    output logic [VC_WIDTH-1:0]            vc_o,
    output logic                           vc_valid_o,
    output logic [$clog2(OUTSTANDING):0]   outstanding_o,
    output logic                           err_o,
    output logic [31:0]                    perf_dec_cnt_o,
    output logic [31:0]                    perf_stall_cnt_o
);

    localparam int unsigned PTR_W = $clog2(OUTSTANDING);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic                  full, hs, pop, hit, push_dec, head_dec;
    logic [DATA_WIDTH-1:0] dec_data;

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] tag_mem_q [OUTSTANDING];
    logic [OUTSTANDING-1:0] dec_mem_q;

    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic [VC_WIDTH-1:0]   vc_q, vc_d;
    logic                  vcv_q, vcv_d;
    logic                  err_q, err_d;

    // Full is judged on the registered count only; a same-cycle pop does not free a slot.
    assign full     = (cnt_q == CNT_W'(OUTSTANDING));
    assign m_req_o  = s_req_i & ~full;
    assign s_gnt_o  = m_gnt_i & ~full;
    assign m_add_o  = s_add_i;
    assign m_wen_o  = s_wen_i;
    assign m_wdata_o = s_wdata_i;
    assign m_be_o   = s_be_i;

    assign hs       = s_req_i & s_gnt_o;
    assign hit      = ((s_add_i & cfg_mask_i) == cfg_base_i);
    assign push_dec = cfg_en_i & s_wen_i & hit;
    assign pop      = m_r_valid_i & (cnt_q != '0);
    assign head_dec = dec_mem_q[rd_ptr_q];
    assign dec_data = m_r_rdata_i ^ cfg_key_i ^ tag_mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rvalid_d = m_r_valid_i;
        vc_d     = vc_q;
        vcv_d    = vcv_q;
        err_d    = err_q;
        if (hs)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({hs, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        if (m_r_valid_i) begin
            if (pop && head_dec) begin
                rdata_d = dec_data;
                vc_d    = dec_data[VC_WIDTH-1:0];
                vcv_d   = 1'b1;
            end else begin
                rdata_d = m_r_rdata_i;
            end
            if (!pop) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            vc_q     <= '0;
            vcv_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            vc_q     <= vc_d;
            vcv_q    <= vcv_d;
            err_q    <= err_d;
        end
    end

    // Entry storage needs no reset: the pointers define which slots are live.
    always_ff @(posedge clk_i) begin
        if (hs) begin
            tag_mem_q[wr_ptr_q] <= s_add_i[DATA_WIDTH-1:0];
            dec_mem_q[wr_ptr_q] <= push_dec;
        end
    end

    assign s_r_rdata_o   = rdata_q;
    assign s_r_valid_o   = rvalid_q;
    assign vc_o          = vc_q;
    assign vc_valid_o    = vcv_q;
    assign outstanding_o = cnt_q;
    assign err_o         = err_q;

`ifdef APE_CORE_PERF_EN
    logic [31:0] dec_cnt_q, stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dec_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (pop && head_dec && (dec_cnt_q != '1))       dec_cnt_q   <= dec_cnt_q + 32'd1;
            if (s_req_i && full && (stall_cnt_q != '1))     stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_dec_cnt_o   = dec_cnt_q;
    assign perf_stall_cnt_o = stall_cnt_q;
`else
    assign perf_dec_cnt_o   = '0;
    assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ape_tcdm_crypt_bridge.sv
// Directed and randomized checks of ape_tcdm_crypt_bridge against a queue-based reference model.
module tb_ape_tcdm_crypt_bridge;
    localparam int OS = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        s_req_i = 1'b0, s_wen_i = 1'b0, m_gnt_i = 1'b0, m_r_valid_i = 1'b0, cfg_en_i = 1'b0;
    logic [31:0] s_add_i = '0, s_wdata_i = '0, m_r_rdata_i = '0, cfg_key_i = '0, cfg_base_i = '0, cfg_mask_i = '0;
    logic [3:0]  s_be_i = '0;
    logic        s_gnt_o, s_r_valid_o, m_req_o, m_wen_o, vc_valid_o, err_o;
    logic [31:0] s_r_rdata_o, m_add_o, m_wdata_o, perf_dec_cnt_o, perf_stall_cnt_o;
    logic [3:0]  m_be_o;
    logic [15:0] vc_o;
    logic [2:0]  outstanding_o;

    ape_tcdm_crypt_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .OUTSTANDING(OS), .VC_WIDTH(16)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_req_i(s_req_i), .s_add_i(s_add_i), .s_wen_i(s_wen_i), .s_wdata_i(s_wdata_i), .s_be_i(s_be_i),
        .s_gnt_o(s_gnt_o), .s_r_rdata_o(s_r_rdata_o), .s_r_valid_o(s_r_valid_o),
        .m_req_o(m_req_o), .m_add_o(m_add_o), .m_wen_o(m_wen_o), .m_wdata_o(m_wdata_o), .m_be_o(m_be_o),
        .m_gnt_i(m_gnt_i), .m_r_rdata_i(m_r_rdata_i), .m_r_valid_i(m_r_valid_i),
        .cfg_en_i(cfg_en_i), .cfg_key_i(cfg_key_i), .cfg_base_i(cfg_base_i), .cfg_mask_i(cfg_mask_i),
        .vc_o(vc_o), .vc_valid_o(vc_valid_o), .outstanding_o(outstanding_o), .err_o(err_o),
        .perf_dec_cnt_o(perf_dec_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned tests = 0, fails = 0;

    // Reference model state
    bit          qd[$];
    logic [31:0] qt[$];
    logic [31:0] exp_rdata = '0;
    logic        exp_valid = 1'b0, exp_vcv = 1'b0, exp_err = 1'b0;
    logic [15:0] exp_vc = '0;
    int unsigned exp_dec = 0, exp_stall = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        qd.delete();
        qt.delete();
        exp_rdata = '0; exp_valid = 1'b0; exp_vcv = 1'b0; exp_err = 1'b0; exp_vc = '0;
        exp_dec = 0; exp_stall = 0;
    endtask

    task automatic check_regs();
        chk("s_r_valid", s_r_valid_o, exp_valid);
        chk("s_r_rdata", s_r_rdata_o, exp_rdata);
        chk("vc", vc_o, exp_vc);
        chk("vc_valid", vc_valid_o, exp_vcv);
        chk("err", err_o, exp_err);
        chk("outstanding", outstanding_o, qd.size());
`ifdef APE_CORE_PERF_EN
        chk("perf_dec", perf_dec_cnt_o, exp_dec);
        chk("perf_stall", perf_stall_cnt_o, exp_stall);
`else
        chk("perf_dec_tied", perf_dec_cnt_o, 0);
        chk("perf_stall_tied", perf_stall_cnt_o, 0);
`endif
    endtask

    // Inputs are set at posedge+1; comb outputs are checked mid-cycle, registered ones after the edge.
    task automatic cycle();
        bit          full, hs, d;
        logic [31:0] t;
        #2;
        full = (qd.size() == OS);
        chk("m_req", m_req_o, s_req_i && !full);
        chk("s_gnt", s_gnt_o, m_gnt_i && !full);
        chk("m_add", m_add_o, s_add_i);
        chk("m_fwd", {m_wen_o, m_be_o, m_wdata_o}, {s_wen_i, s_be_i, s_wdata_i});
        hs = s_req_i && m_gnt_i && !full;
        if (s_req_i && full) exp_stall++;
        exp_valid = m_r_valid_i;
        if (m_r_valid_i) begin
            if (qd.size() != 0) begin
                d = qd.pop_front();
                t = qt.pop_front();
                if (d) begin
                    exp_rdata = m_r_rdata_i ^ cfg_key_i ^ t;
                    exp_vc    = exp_rdata[15:0];
                    exp_vcv   = 1'b1;
                    exp_dec++;
                end else begin
                    exp_rdata = m_r_rdata_i;
                end
            end else begin
                exp_rdata = m_r_rdata_i;
                exp_err   = 1'b1;
            end
        end
        if (hs) begin
            qd.push_back(cfg_en_i && s_wen_i && ((s_add_i & cfg_mask_i) == cfg_base_i));
            qt.push_back(s_add_i);
        end
        @(posedge clk_i);
        #1;
        check_regs();
    endtask

    task automatic drain();
        s_req_i = 1'b0;
        for (int i = 0; i < 16 && qd.size() != 0; i++) begin
            m_r_valid_i = 1'b1;
            m_r_rdata_i = $urandom;
            cycle();
        end
        m_r_valid_i = 1'b0;
        chk("drained", outstanding_o, 0);
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_m_req", m_req_o, 0);
        check_regs();
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        cycle();

        // Window hit decrypt
        cfg_en_i = 1'b1; cfg_key_i = 32'hA5A5_0000; cfg_base_i = 32'h0000_1000; cfg_mask_i = 32'hFFFF_F000;
        m_gnt_i = 1'b1;
        s_req_i = 1'b1; s_wen_i = 1'b1; s_add_i = 32'h0000_1004;
        cycle();
        s_req_i = 1'b0; m_r_valid_i = 1'b1; m_r_rdata_i = 32'h1234_5678;
        cycle();
        chk("tp_dec_data", s_r_rdata_o, 32'hB791_467C);
        chk("tp_dec_vc", vc_o, 16'h467C);

        // Window miss
        m_r_valid_i = 1'b0; s_req_i = 1'b1; s_add_i = 32'h0000_2000;
        cycle();
        s_req_i = 1'b0; m_r_valid_i = 1'b1; m_r_rdata_i = 32'hDEAD_BEEF;
        cycle();
        chk("tp_miss_data", s_r_rdata_o, 32'hDEAD_BEEF);
        chk("tp_miss_vc", vc_o, 16'h467C);

        // Fill to OUTSTANDING, stall, free one slot
        m_r_valid_i = 1'b0; s_req_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_add_i = 32'h0000_1000 + 32'(4 * i);
            cycle();
        end
        chk("tp_full_cnt", outstanding_o, 4);
        cycle();
        m_r_valid_i = 1'b1; m_r_rdata_i = 32'h0BAD_F00D;
        cycle();
        m_r_valid_i = 1'b0;
        cycle();
        chk("tp_refill_cnt", outstanding_o, 4);
        drain();

        // Push and pop in the same cycle at count 2
        s_req_i = 1'b1; s_add_i = 32'h0000_1010;
        cycle();
        cycle();
        m_r_valid_i = 1'b1; m_r_rdata_i = 32'h5555_AAAA;
        cycle();
        chk("tp_pushpop_cnt", outstanding_o, 2);
        drain();

        // Back-to-back reads across pointer wrap
        for (int i = 0; i < 10; i++) begin
            s_req_i = 1'b1;
            s_add_i = (i % 2 == 0) ? (32'h0000_1000 | 32'(i * 8)) : 32'(i * 32'h0001_0000);
            m_r_valid_i = (i > 0);
            m_r_rdata_i = $urandom;
            cycle();
        end
        drain();

        // Randomized traffic, key held constant
        for (int i = 0; i < 300; i++) begin
            s_req_i     = $urandom_range(0, 1);
            s_wen_i     = $urandom_range(0, 1);
            s_add_i     = ($urandom_range(0, 1) != 0) ? (32'h0000_1000 | ($urandom & 32'hFFF)) : $urandom;
            s_wdata_i   = $urandom;
            s_be_i      = 4'($urandom);
            m_gnt_i     = ($urandom_range(0, 3) != 0);
            cfg_en_i    = ($urandom_range(0, 3) != 0);
            m_r_valid_i = (qd.size() != 0) && ($urandom_range(0, 1) != 0);
            m_r_rdata_i = $urandom;
            cycle();
        end
        m_gnt_i = 1'b1;
        drain();

        // Orphan response: raw data, sticky error
        s_req_i = 1'b0; m_r_valid_i = 1'b1; m_r_rdata_i = 32'hCAFE_F00D;
        cycle();
        chk("tp_err_set", err_o, 1);
        chk("tp_err_raw", s_r_rdata_o, 32'hCAFE_F00D);
        m_r_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("tp_err_sticky", err_o, 1);

        // Asynchronous reset with transactions in flight
        s_req_i = 1'b1; s_wen_i = 1'b1; s_add_i = 32'h0000_1008; cfg_en_i = 1'b1;
        cycle();
        cycle();
        chk("tp_pre_rst_cnt", outstanding_o, 2);
        s_req_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("tp_rst_err", err_o, 0);
        chk("tp_rst_cnt", outstanding_o, 0);
        chk("tp_rst_vcv", vc_valid_o, 0);
        chk("tp_rst_vc", vc_o, 0);
        chk("tp_rst_rdata", s_r_rdata_o, 0);
        model_reset();
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
